keypad_emulator: RTL

- Drives the ROWS side of the 4x4 matrix keypad from the COLS strobes, emulating physical key presses.
- Replays a queue of key codes for self-test and password playback against the keypad scanner.
- Uses the same key-code map as the scanner, so scanner + emulator form a closed loop on-chip or in simulation.
- Each key gets a configurable leading bounce, hold, trailing bounce and inter-key gap.

---
 rtl/keypad_pkg.sv | 66 ++++++
 rtl/keypad_emu_fifo.sv | 91 +++++++++
 rtl/keypad_emulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad: key codes, the code to
// row/column map and the emulator state encoding.
//
// Column c is selected when COLS[c] is low; row r answers by pulling ROWS[r]
// low. Layout (rows top to bottom):
//   c0: 1 4 7 *     c1: 2 5 8 0     c2: 3 6 9 #     c3: A B C D
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } emu_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Returns {row[1:0], col[1:0]} for a key code.
    function automatic logic [3:0] key_to_rc(input logic [3:0] code);
        logic [1:0] row;
        logic [1:0] col;
        row = 2'd0;
        col = 2'd0;
        case (code)
            KEY_1:    begin row = 2'd0; col = 2'd0; end
            KEY_4:    begin row = 2'd1; col = 2'd0; end
            KEY_7:    begin row = 2'd2; col = 2'd0; end
            KEY_STAR: begin row = 2'd3; col = 2'd0; end
            KEY_2:    begin row = 2'd0; col = 2'd1; end
            KEY_5:    begin row = 2'd1; col = 2'd1; end
            KEY_8:    begin row = 2'd2; col = 2'd1; end
            KEY_0:    begin row = 2'd3; col = 2'd1; end
            KEY_3:    begin row = 2'd0; col = 2'd2; end
            KEY_6:    begin row = 2'd1; col = 2'd2; end
            KEY_9:    begin row = 2'd2; col = 2'd2; end
            KEY_HASH: begin row = 2'd3; col = 2'd2; end
            KEY_A:    begin row = 2'd0; col = 2'd3; end
            KEY_B:    begin row = 2'd1; col = 2'd3; end
            KEY_C:    begin row = 2'd2; col = 2'd3; end
            KEY_D:    begin row = 2'd3; col = 2'd3; end
            default:  begin row = 2'd0; col = 2'd0; end
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Synchronous FIFO holding the key codes waiting to be played back.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        synchronous clear (drops all entries)
//   push, din  write request and data (ignored when full)
//   pop, dout  read request and head-of-queue data (ignored when empty)
//   count      occupancy, 0..DEPTH
//   full/empty occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module keypad_emu_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            do_push = push && !full;
            do_pop  = pop && !empty;
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/keypad_emulator.sv
// Matrix keypad emulator: plays queued key codes back onto the active-low
// ROWS lines in answer to the scanner's active-low COLS strobes.
// Each key runs: optional leading bounce, stable hold, optional trailing
// bounce, then a released gap that ends with a one-cycle KEY_DONE pulse.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   KEY_CODE/KEY_VALID  enqueue a key; accepted when KEY_READY is high
//   KEY_READY           queue not full
//   FLUSH               drop the queue and cut the current press short
//   COLS_IN             column strobes from the scanner (active low)
//   ROWS_OUT            registered row answers (active low)
//   BUSY                a key is in progress or queued
//   KEY_DONE            pulse on the last gap cycle of each key
//   FIFO_COUNT          queue occupancy
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int PRESS_CYC     = 50_000_000,
    parameter int RELEASE_CYC   = 50_000_000,
    parameter int BOUNCE_CYC    = 0,
    parameter int BOUNCE_PERIOD = 5000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [3:0]                    KEY_CODE,
    input  logic                          KEY_VALID,
    output logic                          KEY_READY,
    input  logic                          FLUSH,
    input  logic [3:0]                    COLS_IN,
    output logic [3:0]                    ROWS_OUT,
    output logic                          BUSY,
    output logic                          KEY_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int CNT_MAX = max_int(max_int(PRESS_CYC, RELEASE_CYC),
                                     max_int(BOUNCE_CYC, BOUNCE_PERIOD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit BOUNCE_EN = (BOUNCE_CYC > 0);

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST  = CNT_W'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(BOUNCE_PERIOD - 1);

    emu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       rows_q, rows_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       fifo_dout;
    logic [3:0]       rc;
    logic             press_active;
    logic             key_done;

    // A push in the FLUSH cycle is dropped along with the rest of the queue.
    assign KEY_READY = !fifo_full;
    assign fifo_push = KEY_VALID && !fifo_full && !FLUSH;

    keypad_emu_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .clr   (FLUSH),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (KEY_CODE),
        .dout  (fifo_dout),
        .count (FIFO_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_cnt_d = ph_cnt_q;
        phase_d  = phase_q;
        row_d    = row_q;
        col_d    = col_q;
        fifo_pop = 1'b0;
        key_done = 1'b0;
        rc       = key_to_rc(fifo_dout);

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !FLUSH) begin
                    fifo_pop = 1'b1;
                    row_d    = rc[3:2];
                    col_d    = rc[1:0];
                    cnt_d    = '0;
                    ph_cnt_d = '0;
                    phase_d  = 1'b1;
                    state_d  = BOUNCE_EN ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                // Bounce phase starts pressed and flips every BOUNCE_PERIOD cycles.
                if (ph_cnt_q == PERIOD_LAST) begin
                    ph_cnt_d = '0;
                    phase_d  = !phase_q;
                end else begin
                    ph_cnt_d = ph_cnt_q + CNT_W'(1);
                end
                if (cnt_q == BOUNCE_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == BOUNCE_IN) ? HOLD : GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == PRESS_LAST) begin
                    cnt_d    = '0;
                    ph_cnt_d = '0;
                    phase_d  = 1'b1;
                    state_d  = BOUNCE_EN ? BOUNCE_OUT : GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == RELEASE_LAST) begin
                    key_done = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // An aborted press still gets its full release gap.
        if (FLUSH && (state_q == BOUNCE_IN || state_q == HOLD || state_q == BOUNCE_OUT)) begin
            state_d = GAP;
            cnt_d   = '0;
        end
    end

    always_comb begin
        press_active = (state_q == HOLD) ||
                       ((state_q == BOUNCE_IN || state_q == BOUNCE_OUT) && phase_q);
        rows_d = 4'hF;
        if (press_active && !COLS_IN[col_q]) begin
            rows_d[row_q] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ph_cnt_q <= '0;
            phase_q  <= 1'b0;
            row_q    <= 2'd0;
            col_q    <= 2'd0;
            rows_q   <= 4'hF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_cnt_q <= ph_cnt_d;
            phase_q  <= phase_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rows_q   <= rows_d;
        end
    end

    assign ROWS_OUT = rows_q;
    assign KEY_DONE = key_done;
    assign BUSY     = (state_q != IDLE) || !fifo_empty;

endmodule
